// File: rtl/m_stage.sv
// -----------------------------------------------------------------------------
// m_stage -- memory stage of the in-order core pipeline (X_stage -> M -> W_stage)
//
// Registers the X-stage result and control, issues loads/stores to data memory
// over a req/gnt/rvalid handshake, formats load data (byte-lane extract plus
// sign/zero extend) and forwards the write-back value, rf_ctrl packet and valid
// to W_stage. Takes part in the stall/squash chain: it holds X while a memory
// access is outstanding and passes W's stall/squash upstream.
//
// Optional feature (compile-time macro M_STAGE_MISALIGN_TRAP_EN):
//   defined   -> a misaligned half/word access issues no request and raises
//                squash to X while it sits in the stage; its valid is dropped.
//   undefined -> no alignment check; low address bits are simply truncated.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   rf_ctrl_pkt_in/out  register-file control packet from X / registered to W
//   alu_result_in       ALU result or effective address
//   store_data_in       rs2 value for stores
//   mem_rd_in/mem_wr_in instruction is a load / store
//   mem_size_in         0=byte, 1=half, 2=word (3 behaves as word)
//   mem_uns_in          zero-extend loads (LBU/LHU)
//   data_out            write-back value to W
//   vld_in / vld        valid from X / valid to W
//   stall_in / stall    stall from W / stall to X
//   squash_in / squash  squash from W / squash to X
//   dmem_req/we/be/addr/wdata   data memory request (all 0 when dmem_req=0)
//   dmem_gnt/rvalid/rdata       data memory grant, response and load data
// -----------------------------------------------------------------------------

package core_types_pkg;

  localparam int N_BITS = 32;

  typedef struct packed {
    logic       rf_we;
    logic [4:0] rd_addr;
  } rf_ctrl_t;

endpackage

module m_stage #(
  parameter int N_BITS         = core_types_pkg::N_BITS,
  parameter int DMEM_ADDR_BITS = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [$bits(core_types_pkg::rf_ctrl_t)-1:0] rf_ctrl_pkt_in,
  output logic [$bits(core_types_pkg::rf_ctrl_t)-1:0] rf_ctrl_pkt_out,
  input  logic [N_BITS-1:0]                       alu_result_in,
  input  logic [N_BITS-1:0]                       store_data_in,
  input  logic                                    mem_rd_in,
  input  logic                                    mem_wr_in,
  input  logic [1:0]                              mem_size_in,
  input  logic                                    mem_uns_in,
  output logic [N_BITS-1:0]                       data_out,
  input  logic                                    vld_in,
  output logic                                    vld,
  input  logic                                    stall_in,
  output logic                                    stall,
  input  logic                                    squash_in,
  output logic                                    squash,
  output logic                                    dmem_req,
  output logic                                    dmem_we,
  output logic [3:0]                              dmem_be,
  output logic [DMEM_ADDR_BITS-1:0]               dmem_addr,
  output logic [N_BITS-1:0]                       dmem_wdata,
  input  logic                                    dmem_gnt,
  input  logic                                    dmem_rvalid,
  input  logic [N_BITS-1:0]                       dmem_rdata
);

  localparam int RF_W = $bits(core_types_pkg::rf_ctrl_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              vld_raw;
  logic [N_BITS-1:0] alu_q;
  logic [N_BITS-1:0] sd_q;
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [RF_W-1:0]   rf_q;
  logic [N_BITS-1:0] rdata_q;

  logic              memop;
  logic              misaligned;
  logic              issue_ok;
  logic              req;
  logic              capture;
  logic              gen_stall;
  logic              gen_squash;
  logic              stall_int;
  logic [1:0]        addr_lo;

  logic [3:0]        be;
  logic [N_BITS-1:0] wdata;
  logic [N_BITS-1:0] load_src;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [N_BITS-1:0] load_fmt;

  assign addr_lo = alu_q[1:0];
  assign memop   = vld_raw && (rd_q || wr_q);

  // Pipeline registers: everything X hands over advances together, and only
  // when nothing downstream (W or our own memory access) holds the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_raw <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rf_q    <= '0;
    end else if (!stall_int) begin
      vld_raw <= vld_in;
      alu_q   <= alu_result_in;
      sd_q    <= store_data_in;
      rd_q    <= mem_rd_in;
      wr_q    <= mem_wr_in;
      size_q  <= mem_size_in;
      uns_q   <= mem_uns_in;
      rf_q    <= rf_ctrl_pkt_in;
    end
  end

`ifdef M_STAGE_MISALIGN_TRAP_EN
  // Half accesses need an even address, word accesses (and size 3, which
  // behaves as word) need a word-aligned one.
  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  // A trapping memop never leaves IDLE, so the squash lasts exactly as long
  // as the instruction sits in the stage.
  assign gen_squash = memop && misaligned && (state_q == IDLE);
`else
  assign misaligned = 1'b0;
  assign gen_squash = 1'b0;
`endif

  assign issue_ok = !squash_in && !misaligned;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Once a request is presented it stays up until granted,
  // even if W squashes meanwhile: the handshake is always completed and the
  // result is simply not marked valid.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && issue_ok) begin
          req     = 1'b1;
          state_d = dmem_gnt ? RESP : REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          if (stall_in) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (!stall_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data is only on the bus for one cycle; keep a copy when W is
  // not ready to take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= dmem_rdata;
    end
  end

  // The stage holds X until the response has arrived. HOLD deliberately does
  // not stall by itself: stall_in already keeps the registers frozen there,
  // and dropping the stall the moment W releases lets the registers advance in
  // the same cycle the FSM returns to IDLE, so the memop is never reissued.
  always_comb begin
    gen_stall = 1'b0;
    if (memop) begin
      case (state_q)
        IDLE:    gen_stall = issue_ok;
        REQ:     gen_stall = 1'b1;
        RESP:    gen_stall = !dmem_rvalid;
        default: gen_stall = 1'b0;
      endcase
    end
  end

  assign stall_int = stall_in || gen_stall;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = sd_q;
    case (size_q)
      2'd0: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{sd_q[7:0]}};
      end
      2'd1: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{sd_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = sd_q;
      end
    endcase
  end

  // Load formatting: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    load_src  = (state_q == HOLD) ? rdata_q : dmem_rdata;
    load_byte = load_src[{addr_lo, 3'b000} +: 8];
    load_half = load_src[{addr_lo[1], 4'b0000} +: 16];
    load_fmt  = load_src;
    case (size_q)
      2'd0: begin
        load_fmt = uns_q ? {{(N_BITS-8){1'b0}}, load_byte}
                         : {{(N_BITS-8){load_byte[7]}}, load_byte};
      end
      2'd1: begin
        load_fmt = uns_q ? {{(N_BITS-16){1'b0}}, load_half}
                         : {{(N_BITS-16){load_half[15]}}, load_half};
      end
      default: load_fmt = load_src;
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = req && wr_q;
  assign dmem_be    = req ? be : 4'b0000;
  assign dmem_addr  = req ? {alu_q[DMEM_ADDR_BITS-1:2], 2'b00} : '0;
  assign dmem_wdata = req ? wdata : '0;

  assign data_out        = rd_q ? load_fmt : alu_q;
  assign rf_ctrl_pkt_out = rf_q;

  assign vld = vld_raw && !gen_stall && !squash_in && !gen_squash;

  // stall_in/squash_in would otherwise pass straight through during reset.
  assign stall  = rst_n && stall_int;
  assign squash = rst_n && (squash_in || gen_squash);

endmodule

// File: tb/tb_m_stage.sv
// -----------------------------------------------------------------------------
// tb_m_stage -- directed self-checking bench for m_stage.
// A table of single load/store transactions (gnt in the request cycle, rvalid
// in the next) is run in a loop, followed by hand-written sequences for the
// multi-cycle cases: waiting for rvalid, delayed grant with HOLD, squash in
// flight and in IDLE, non-memory ops, reset mid-access and the misalign trap.
// -----------------------------------------------------------------------------

module tb_m_stage;

  localparam int RF_W = $bits(core_types_pkg::rf_ctrl_t);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RF_W-1:0] rf_ctrl_pkt_in;
  logic [RF_W-1:0] rf_ctrl_pkt_out;
  logic [31:0]     alu_result_in;
  logic [31:0]     store_data_in;
  logic            mem_rd_in;
  logic            mem_wr_in;
  logic [1:0]      mem_size_in;
  logic            mem_uns_in;
  logic [31:0]     data_out;
  logic            vld_in;
  logic            vld;
  logic            stall_in;
  logic            stall;
  logic            squash_in;
  logic            squash;
  logic            dmem_req;
  logic            dmem_we;
  logic [3:0]      dmem_be;
  logic [31:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [31:0]     dmem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  m_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rf_ctrl_pkt_in  (rf_ctrl_pkt_in),
    .rf_ctrl_pkt_out (rf_ctrl_pkt_out),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .mem_rd_in       (mem_rd_in),
    .mem_wr_in       (mem_wr_in),
    .mem_size_in     (mem_size_in),
    .mem_uns_in      (mem_uns_in),
    .data_out        (data_out),
    .vld_in          (vld_in),
    .vld             (vld),
    .stall_in        (stall_in),
    .stall           (stall),
    .squash_in       (squash_in),
    .squash          (squash),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_be         (dmem_be),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic        rd;
    logic        wr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic rd, input logic wr, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_dout);
    vec_t v;
    v.name = name; v.addr = addr; v.size = size; v.uns = uns; v.rd = rd; v.wr = wr;
    v.sd = sd; v.rdata = rdata; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_dout = exp_dout;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [RF_W-1:0] rf);
    vld_in         = v;
    mem_rd_in      = rd;
    mem_wr_in      = wr;
    mem_size_in    = size;
    mem_uns_in     = uns;
    alu_result_in  = addr;
    store_data_in  = sd;
    rf_ctrl_pkt_in = rf;
  endtask

  task automatic applyBubble();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, '0);
  endtask

  // One transaction: X hands it over, gnt in the request cycle, rvalid next.
  task automatic runVector(input vec_t v, input logic [RF_W-1:0] rf);
    step();
    applyStimulus(1'b1, v.rd, v.wr, v.size, v.uns, v.addr, v.sd, rf);
    step();
    applyBubble();
    dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("%s.req", v.name), 32'(dmem_req), 32'd1);
    checkOutput($sformatf("%s.addr", v.name), dmem_addr, {v.addr[31:2], 2'b00});
    checkOutput($sformatf("%s.we", v.name), 32'(dmem_we), 32'(v.wr));
    checkOutput($sformatf("%s.be", v.name), 32'(dmem_be), 32'(v.exp_be));
    checkOutput($sformatf("%s.wdata", v.name), dmem_wdata, v.exp_wdata);
    checkOutput($sformatf("%s.stall_req", v.name), 32'(stall), 32'd1);
    checkOutput($sformatf("%s.vld_req", v.name), 32'(vld), 32'd0);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = v.rdata;
    @(negedge clk);
    checkOutput($sformatf("%s.dout", v.name), data_out, v.exp_dout);
    checkOutput($sformatf("%s.vld", v.name), 32'(vld), 32'd1);
    checkOutput($sformatf("%s.stall_resp", v.name), 32'(stall), 32'd0);
    checkOutput($sformatf("%s.req_resp", v.name), 32'(dmem_req), 32'd0);
    checkOutput($sformatf("%s.rf", v.name), 32'(rf_ctrl_pkt_out), 32'(rf));
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    @(negedge clk);
    checkOutput($sformatf("%s.vld_after", v.name), 32'(vld), 32'd0);
    checkOutput($sformatf("%s.req_after", v.name), 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n       = 1'b0;
    stall_in    = 1'b0;
    squash_in   = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    applyBubble();

    //     name         addr          sz  uns rd wr  sd            rdata         be       wdata         dout
    addVec("lw_100",    32'h0000_0100, 2'd2, 0, 1, 0, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    addVec("lb_103",    32'h0000_0103, 2'd0, 0, 1, 0, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0,        32'hFFFF_FF80);
    addVec("lbu_103",   32'h0000_0103, 2'd0, 1, 1, 0, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0,        32'h0000_0080);
    addVec("lb_101",    32'h0000_0101, 2'd0, 0, 1, 0, 32'h0,        32'h1234_5678, 4'b0010, 32'h0,        32'h0000_0056);
    addVec("lh_102",    32'h0000_0102, 2'd1, 0, 1, 0, 32'h0,        32'h8001_7FFF, 4'b1100, 32'h0,        32'hFFFF_8001);
    addVec("lhu_100",   32'h0000_0100, 2'd1, 1, 1, 0, 32'h0,        32'h8001_F00F, 4'b0011, 32'h0,        32'h0000_F00F);
    addVec("sh_102",    32'h0000_0102, 2'd1, 0, 0, 1, 32'h1234_ABCD, 32'h0,        4'b1100, 32'hABCD_ABCD, 32'h0000_0102);
    addVec("sb_201",    32'h0000_0201, 2'd0, 0, 0, 1, 32'h0000_00A5, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0000_0201);
    addVec("sw_304",    32'h0000_0304, 2'd2, 0, 0, 1, 32'hCAFE_F00D, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0000_0304);
    addVec("lsz3_400",  32'h0000_0400, 2'd3, 0, 1, 0, 32'h0,        32'h8765_4321, 4'b1111, 32'h0,        32'h8765_4321);
`ifndef M_STAGE_MISALIGN_TRAP_EN
    addVec("lw_mis102", 32'h0000_0102, 2'd2, 0, 1, 0, 32'h0,        32'h1357_2468, 4'b1111, 32'h0,        32'h1357_2468);
`endif

    // Reset state
    @(negedge clk);
    checkOutput("reset.req", 32'(dmem_req), 32'd0);
    checkOutput("reset.vld", 32'(vld), 32'd0);
    checkOutput("reset.stall", 32'(stall), 32'd0);
    checkOutput("reset.squash", 32'(squash), 32'd0);
    checkOutput("reset.dout", data_out, 32'd0);
    checkOutput("reset.rf", 32'(rf_ctrl_pkt_out), 32'd0);
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      runVector(vecs[i], RF_W'(i + 33));
    end

    // Word load with one wait cycle before rvalid: stall for two cycles
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, RF_W'(5));
    step();
    applyBubble();
    dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("wait.stall1", 32'(stall), 32'd1);
    checkOutput("wait.req1", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("wait.stall2", 32'(stall), 32'd1);
    checkOutput("wait.req2", 32'(dmem_req), 32'd0);
    checkOutput("wait.vld2", 32'(vld), 32'd0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("wait.stall3", 32'(stall), 32'd0);
    checkOutput("wait.vld3", 32'(vld), 32'd1);
    checkOutput("wait.dout3", data_out, 32'hDEAD_BEEF);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;

    // Grant delayed three cycles, then rvalid under stall_in -> HOLD
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0208, 32'h0, RF_W'(9));
    step();
    applyBubble();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("gnt_delay.req%0d", k), 32'(dmem_req), 32'd1);
      checkOutput($sformatf("gnt_delay.addr%0d", k), dmem_addr, 32'h0000_0208);
      checkOutput($sformatf("gnt_delay.stall%0d", k), 32'(stall), 32'd1);
      step();
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("gnt_delay.req_gnt", 32'(dmem_req), 32'd1);
    checkOutput("gnt_delay.addr_gnt", dmem_addr, 32'h0000_0208);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1122_3344;
    stall_in    = 1'b1;
    @(negedge clk);
    checkOutput("hold.dout_rvalid", data_out, 32'h1122_3344);
    checkOutput("hold.stall_rvalid", 32'(stall), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      checkOutput($sformatf("hold.dout%0d", k), data_out, 32'h1122_3344);
      checkOutput($sformatf("hold.req%0d", k), 32'(dmem_req), 32'd0);
      checkOutput($sformatf("hold.stall%0d", k), 32'(stall), 32'd1);
    end
    step();
    stall_in = 1'b0;
    @(negedge clk);
    checkOutput("hold.dout_rel", data_out, 32'h1122_3344);
    checkOutput("hold.vld_rel", 32'(vld), 32'd1);
    checkOutput("hold.stall_rel", 32'(stall), 32'd0);
    checkOutput("hold.req_rel", 32'(dmem_req), 32'd0);
    step();
    dmem_rdata = 32'h0;
    @(negedge clk);
    checkOutput("hold.vld_after", 32'(vld), 32'd0);
    checkOutput("hold.req_after", 32'(dmem_req), 32'd0);

    // Squash arriving while the request waits for gnt and the response
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, RF_W'(3));
    step();
    applyBubble();
    @(negedge clk);
    checkOutput("sq_flight.req_idle", 32'(dmem_req), 32'd1);
    step();
    squash_in = 1'b1;
    dmem_gnt  = 1'b1;
    @(negedge clk);
    checkOutput("sq_flight.req_kept", 32'(dmem_req), 32'd1);
    checkOutput("sq_flight.addr_kept", dmem_addr, 32'h0000_0300);
    checkOutput("sq_flight.squash", 32'(squash), 32'd1);
    checkOutput("sq_flight.vld_req", 32'(vld), 32'd0);
    step();
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("sq_flight.stall_resp", 32'(stall), 32'd1);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    checkOutput("sq_flight.vld_rvalid", 32'(vld), 32'd0);
    checkOutput("sq_flight.stall_rvalid", 32'(stall), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    squash_in   = 1'b0;
    @(negedge clk);
    checkOutput("sq_flight.req_after", 32'(dmem_req), 32'd0);
    checkOutput("sq_flight.vld_after", 32'(vld), 32'd0);

    // Squash while the memop is in IDLE: no request at all
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, RF_W'(3));
    step();
    applyBubble();
    squash_in = 1'b1;
    @(negedge clk);
    checkOutput("sq_idle.req", 32'(dmem_req), 32'd0);
    checkOutput("sq_idle.stall", 32'(stall), 32'd0);
    checkOutput("sq_idle.vld", 32'(vld), 32'd0);
    checkOutput("sq_idle.squash", 32'(squash), 32'd1);
    step();
    squash_in = 1'b0;
    @(negedge clk);
    checkOutput("sq_idle.req_after", 32'(dmem_req), 32'd0);
    checkOutput("sq_idle.vld_after", 32'(vld), 32'd0);

    // Non-memory instruction passes the ALU result straight through
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_55AA, 32'h0, RF_W'(7));
    step();
    applyBubble();
    @(negedge clk);
    checkOutput("alu.vld", 32'(vld), 32'd1);
    checkOutput("alu.dout", data_out, 32'h0000_55AA);
    checkOutput("alu.req", 32'(dmem_req), 32'd0);
    checkOutput("alu.stall", 32'(stall), 32'd0);

`ifdef M_STAGE_MISALIGN_TRAP_EN
    // Misaligned word load traps instead of issuing
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, RF_W'(4));
    step();
    applyBubble();
    @(negedge clk);
    checkOutput("trap.req", 32'(dmem_req), 32'd0);
    checkOutput("trap.squash", 32'(squash), 32'd1);
    checkOutput("trap.vld", 32'(vld), 32'd0);
    checkOutput("trap.stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    checkOutput("trap.squash_after", 32'(squash), 32'd0);
    checkOutput("trap.req_after", 32'(dmem_req), 32'd0);
`endif

    // Asynchronous reset in the middle of RESP
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, RF_W'(6));
    step();
    applyBubble();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_resp.req", 32'(dmem_req), 32'd0);
    checkOutput("rst_resp.vld", 32'(vld), 32'd0);
    checkOutput("rst_resp.stall", 32'(stall), 32'd0);
    checkOutput("rst_resp.rf", 32'(rf_ctrl_pkt_out), 32'd0);
    step();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("rst_resp.vld_stray", 32'(vld), 32'd0);
    checkOutput("rst_resp.dout_stray", data_out, 32'd0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    runVector(vecs[0], RF_W'(17));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
